// File: rtl/inst_fetch_queue_pkg.sv
// Shared widths, handshake levels and FSM encoding
// for the prefetching instruction-fetch stage.
package inst_fetch_queue_pkg;

    localparam int ADDR_LEN = 32;
    localparam int INST_LEN = 32;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    localparam logic [31:0] ZERO_WORD = 32'h0;

    typedef enum logic [1:0] {
        IF_IDLE = 2'd0,
        IF_WAIT = 2'd1,
        IF_DROP = 2'd2
    } if_state_t;

endpackage

// File: rtl/inst_fetch_queue_fetch_fifo.sv
// Prefetch queue: registered storage of {pc, inst} entries.
// Flush wins over push and pop; pointers wrap naturally.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           head,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_C);
    assign do_push = push && !flush && (!full || pop);
    assign do_pop  = pop && !flush && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk_in) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/inst_fetch_queue.sv
// Prefetching fetch stage: one outstanding word request,
// DEPTH-entry queue toward IF_ID, jump flush with stale-drop.
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int              ADDR_W   = ADDR_LEN,
    parameter int              INST_W   = INST_LEN,
    parameter int              DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              jump_en_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    input  logic              stall_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_done_i,
    input  logic [INST_W-1:0] mem_data_i,
    output logic              inst_valid_o,
    output logic [INST_W-1:0] inst_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] next_pc_o
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int ENT_W = ADDR_W + INST_W;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    if_state_t         state_q;
    if_state_t         state_d;
    logic [ADDR_W-1:0] fetch_pc_q;
    logic [ADDR_W-1:0] fetch_pc_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;

    logic              push;
    logic              pop;
    logic              flush;
    logic              empty;
    logic              full;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_after;
    logic [ENT_W-1:0]  head;
    logic [ADDR_W-1:0] jump_tgt;
    logic [ADDR_W-1:0] pc_inc;

    assign jump_tgt = {jump_addr_i[ADDR_W-1:2], 2'b00};
    assign pc_inc   = fetch_pc_q + ADDR_W'(4);

    assign pop = !empty && !stall_i && rdy_in && !jump_en_i;

    // Occupancy once the word returning this cycle has landed.
    assign count_after = count + CNT_W'(1) - CNT_W'(pop);

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        push       = DISABLE;
        flush      = DISABLE;
        unique case (state_q)
            IF_IDLE: begin
                if (jump_en_i) begin
                    fetch_pc_d = jump_tgt;
                    flush      = ENABLE;
                end else if (!full) begin
                    state_d = IF_WAIT;
                    addr_d  = fetch_pc_q;
                end
            end
            IF_WAIT: begin
                if (jump_en_i) begin
                    fetch_pc_d = jump_tgt;
                    flush      = ENABLE;
                    state_d    = mem_done_i ? IF_IDLE : IF_DROP;
                end else if (mem_done_i) begin
                    push       = ENABLE;
                    fetch_pc_d = pc_inc;
                    if (count_after < DEPTH_C) begin
                        addr_d = pc_inc;
                    end else begin
                        state_d = IF_IDLE;
                    end
                end
            end
            IF_DROP: begin
                // MEMCTRL cannot abort, so wait out the stale word.
                if (jump_en_i) begin
                    fetch_pc_d = jump_tgt;
                    flush      = ENABLE;
                end
                if (mem_done_i) begin
                    state_d = IF_IDLE;
                end
            end
            default: begin
                state_d = IF_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= IF_IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= '0;
        end else if (rdy_in) begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .push   (push && rdy_in),
        .pop    (pop),
        .flush  (flush && rdy_in),
        .din    ({fetch_pc_q, mem_data_i}),
        .head   (head),
        .empty  (empty),
        .full   (full),
        .count  (count)
    );

    assign mem_req_o    = (state_q != IF_IDLE);
    assign mem_addr_o   = addr_q;
    assign inst_valid_o = !empty;
    assign inst_o       = empty ? '0 : head[INST_W-1:0];
    assign pc_o         = empty ? '0 : head[ENT_W-1:INST_W];
    assign next_pc_o    = empty ? '0 : head[ENT_W-1:INST_W] + ADDR_W'(4);

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue with a small MEMCTRL responder.
// Expected values are hand-derived addresses and word_of() patterns.
module tb_inst_fetch_queue;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in = 1'b1;
    logic        jump_en_i = 1'b0;
    logic [31:0] jump_addr_i = '0;
    logic        stall_i = 1'b0;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_done_i = 1'b0;
    logic [31:0] mem_data_i = '0;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic [31:0] next_pc_o;

    int n_checks = 0;
    int n_fail = 0;
    bit auto_en = 1'b0;
    int ack_delay = 1;
    int ack_cnt = 0;
    logic [31:0] acked [$];

    inst_fetch_queue #(
        .ADDR_W   (32),
        .INST_W   (32),
        .DEPTH    (4),
        .RESET_PC (32'h100)
    ) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .rdy_in       (rdy_in),
        .jump_en_i    (jump_en_i),
        .jump_addr_i  (jump_addr_i),
        .stall_i      (stall_i),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_done_i   (mem_done_i),
        .mem_data_i   (mem_data_i),
        .inst_valid_o (inst_valid_o),
        .inst_o       (inst_o),
        .pc_o         (pc_o),
        .next_pc_o    (next_pc_o)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    // Auto-acking MEMCTRL: done after ack_delay cycles of request.
    initial forever begin
        @(negedge clk_in);
        if (auto_en) begin
            if (mem_req_o) begin
                ack_cnt++;
                if (ack_cnt >= ack_delay) begin
                    mem_done_i = 1'b1;
                    mem_data_i = word_of(mem_addr_o);
                    acked.push_back(mem_addr_o);
                    ack_cnt = 0;
                end else begin
                    mem_done_i = 1'b0;
                end
            end else begin
                mem_done_i = 1'b0;
                ack_cnt = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #2;
    endtask

    task automatic do_reset();
        auto_en = 1'b0;
        ack_cnt = 0;
        mem_done_i = 1'b0;
        jump_en_i = 1'b0;
        stall_i = 1'b0;
        rdy_in = 1'b1;
        rst_in = 1'b1;
        acked.delete();
        tick();
        tick();
        rst_in = 1'b0;
    endtask

    task automatic wait_req();
        int i;
        for (i = 0; i < 20; i++) begin
            tick();
            if (mem_req_o === 1'b1) break;
        end
        n_checks++;
        if (i == 20) begin
            n_fail++;
            $display("FAIL wait_req: got no request, required mem_req_o=1");
        end
    endtask

    task automatic ack_now();
        mem_done_i = 1'b1;
        mem_data_i = word_of(mem_addr_o);
        tick();
        mem_done_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({mem_req_o, inst_valid_o} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_flags: got req/valid %b%b required 00", mem_req_o, inst_valid_o);
        end
        n_checks++;
        if ({mem_addr_o, inst_o, pc_o, next_pc_o} !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h %h %h %h required 0", mem_addr_o, inst_o, pc_o, next_pc_o);
        end
    endtask

    task automatic test_stream();
        int seen = 0;
        do_reset();
        ack_delay = 3;
        auto_en = 1'b1;
        for (int c = 0; c < 60 && seen < 3; c++) begin
            tick();
            n_checks++;
            if (inst_valid_o !== mem_done_i) begin
                n_fail++;
                $display("FAIL stream_valid: got %b required %b", inst_valid_o, mem_done_i);
            end
            if (mem_done_i === 1'b1) begin
                n_checks++;
                if (pc_o !== 32'h100 + 32'(4 * seen) || inst_o !== word_of(32'h100 + 32'(4 * seen))) begin
                    n_fail++;
                    $display("FAIL stream_word: got pc %h inst %h required pc %h", pc_o, inst_o, 32'h100 + 32'(4 * seen));
                end
                n_checks++;
                if (next_pc_o !== 32'h104 + 32'(4 * seen)) begin
                    n_fail++;
                    $display("FAIL stream_next_pc: got %h required %h", next_pc_o, 32'h104 + 32'(4 * seen));
                end
                seen++;
            end
        end
        n_checks++;
        if (acked.size() < 3) begin
            n_fail++;
            $display("FAIL stream_acks: got %0d acks required 3", acked.size());
        end else if (acked[0] !== 32'h100 || acked[1] !== 32'h104 || acked[2] !== 32'h108) begin
            n_fail++;
            $display("FAIL stream_addrs: got %h %h %h required 100 104 108", acked[0], acked[1], acked[2]);
        end
        auto_en = 1'b0;
        mem_done_i = 1'b0;
    endtask

    task automatic test_stall_full();
        do_reset();
        stall_i = 1'b1;
        ack_delay = 1;
        auto_en = 1'b1;
        for (int c = 0; c < 10; c++) tick();
        n_checks++;
        if (acked.size() != 4) begin
            n_fail++;
            $display("FAIL full_pushes: got %0d required 4", acked.size());
        end else if (acked[0] !== 32'h100 || acked[3] !== 32'h10C) begin
            n_fail++;
            $display("FAIL full_addrs: got %h..%h required 100..10c", acked[0], acked[3]);
        end
        n_checks++;
        if (mem_req_o !== 1'b0 || inst_valid_o !== 1'b1 || pc_o !== 32'h100) begin
            n_fail++;
            $display("FAIL full_hold: got req %b valid %b pc %h required 0 1 100", mem_req_o, inst_valid_o, pc_o);
        end
        stall_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (pc_o !== 32'h104 + 32'(4 * i)) begin
                n_fail++;
                $display("FAIL drain_order: got %h required %h", pc_o, 32'h104 + 32'(4 * i));
            end
        end
        n_checks++;
        if (acked.size() < 5 || acked[4] !== 32'h110) begin
            n_fail++;
            $display("FAIL reissue_addr: got %0d acks required fifth at 110", acked.size());
        end
        auto_en = 1'b0;
        mem_done_i = 1'b0;
    endtask

    task automatic test_jump_wait();
        do_reset();
        stall_i = 1'b1;
        wait_req();
        ack_now();
        ack_now();
        n_checks++;
        if (mem_addr_o !== 32'h108 || pc_o !== 32'h100 || inst_valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL jw_pre: got addr %h pc %h required 108 100", mem_addr_o, pc_o);
        end
        jump_en_i = 1'b1;
        jump_addr_i = 32'h200;
        tick();
        jump_en_i = 1'b0;
        n_checks++;
        if (inst_valid_o !== 1'b0 || mem_req_o !== 1'b1 || mem_addr_o !== 32'h108) begin
            n_fail++;
            $display("FAIL jw_flush: got valid %b req %b addr %h required 0 1 108", inst_valid_o, mem_req_o, mem_addr_o);
        end
        tick();
        ack_now();
        n_checks++;
        if (inst_valid_o !== 1'b0 || mem_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL jw_stale: got valid %b req %b required 0 0", inst_valid_o, mem_req_o);
        end
        tick();
        n_checks++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h200) begin
            n_fail++;
            $display("FAIL jw_redirect: got req %b addr %h required 1 200", mem_req_o, mem_addr_o);
        end
        ack_now();
        n_checks++;
        if (inst_valid_o !== 1'b1 || pc_o !== 32'h200 || inst_o !== word_of(32'h200)) begin
            n_fail++;
            $display("FAIL jw_first: got valid %b pc %h inst %h required 1 200", inst_valid_o, pc_o, inst_o);
        end
    endtask

    task automatic test_jump_done();
        do_reset();
        stall_i = 1'b1;
        wait_req();
        ack_now();
        ack_now();
        ack_now();
        n_checks++;
        if (mem_addr_o !== 32'h10C) begin
            n_fail++;
            $display("FAIL jd_pre: got addr %h required 10c", mem_addr_o);
        end
        mem_done_i = 1'b1;
        mem_data_i = word_of(mem_addr_o);
        jump_en_i = 1'b1;
        jump_addr_i = 32'h303;
        tick();
        mem_done_i = 1'b0;
        jump_en_i = 1'b0;
        n_checks++;
        if (inst_valid_o !== 1'b0 || mem_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL jd_idle: got valid %b req %b required 0 0", inst_valid_o, mem_req_o);
        end
        tick();
        n_checks++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h300) begin
            n_fail++;
            $display("FAIL jd_redirect: got req %b addr %h required 1 300", mem_req_o, mem_addr_o);
        end
        ack_now();
        n_checks++;
        if (pc_o !== 32'h300 || next_pc_o !== 32'h304 || inst_o !== word_of(32'h300)) begin
            n_fail++;
            $display("FAIL jd_first: got pc %h next %h inst %h required 300 304", pc_o, next_pc_o, inst_o);
        end
    endtask

    task automatic test_rdy_freeze();
        do_reset();
        wait_req();
        ack_now();
        rdy_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                mem_done_i = 1'b1;
                mem_data_i = word_of(32'h104);
            end
            tick();
            mem_done_i = 1'b0;
            n_checks++;
            if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h104 || inst_valid_o !== 1'b1 || pc_o !== 32'h100) begin
                n_fail++;
                $display("FAIL rdy_hold: got req %b addr %h valid %b pc %h required 1 104 1 100", mem_req_o, mem_addr_o, inst_valid_o, pc_o);
            end
        end
        rdy_in = 1'b1;
        tick();
        n_checks++;
        if (inst_valid_o !== 1'b0 || mem_req_o !== 1'b1 || mem_addr_o !== 32'h104) begin
            n_fail++;
            $display("FAIL rdy_resume: got valid %b req %b addr %h required 0 1 104", inst_valid_o, mem_req_o, mem_addr_o);
        end
        ack_now();
        n_checks++;
        if (inst_valid_o !== 1'b1 || pc_o !== 32'h104 || inst_o !== word_of(32'h104)) begin
            n_fail++;
            $display("FAIL rdy_next: got valid %b pc %h inst %h required 1 104", inst_valid_o, pc_o, inst_o);
        end
    endtask

    task automatic test_reset_drop();
        do_reset();
        wait_req();
        jump_en_i = 1'b1;
        jump_addr_i = 32'h400;
        tick();
        jump_en_i = 1'b0;
        n_checks++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h100) begin
            n_fail++;
            $display("FAIL rd_drop: got req %b addr %h required 1 100", mem_req_o, mem_addr_o);
        end
        rst_in = 1'b1;
        tick();
        n_checks++;
        if ({mem_req_o, inst_valid_o} !== 2'b00 || {mem_addr_o, inst_o, pc_o, next_pc_o} !== 128'h0) begin
            n_fail++;
            $display("FAIL rd_reset: got req %b valid %b addr %h required all 0", mem_req_o, inst_valid_o, mem_addr_o);
        end
        rst_in = 1'b0;
        mem_done_i = 1'b1;
        mem_data_i = 32'hBAD0_BAD0;
        tick();
        mem_done_i = 1'b0;
        n_checks++;
        if (inst_valid_o !== 1'b0 || mem_req_o !== 1'b1 || mem_addr_o !== 32'h100) begin
            n_fail++;
            $display("FAIL rd_stray: got valid %b req %b addr %h required 0 1 100", inst_valid_o, mem_req_o, mem_addr_o);
        end
        tick();
        n_checks++;
        if (inst_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_stray_late: got valid %b required 0", inst_valid_o);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall_full();
        test_jump_wait();
        test_jump_done();
        test_rdy_freeze();
        test_reset_drop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
